// File: rtl/iq_pkg.sv
// iq_pkg: shared definitions for the instruction prefetch queue.
// Provides the default word/opcode/depth sizes, the opcode encoding of the
// 8-bit ISA, and a helper that splits a default-width word into its fields.
// Optional build macro used by the queue: IQ_BYPASS_EN (empty-queue bypass).
package iq_pkg;

  localparam int IQ_IW    = 8;
  localparam int IQ_OPC_W = 4;
  localparam int IQ_DEPTH = 4;

  // Opcode encoding of the 8-bit ISA (upper nibble of each word)
  typedef enum logic [IQ_OPC_W-1:0] {
    OP_NOP  = 4'h0,
    OP_LDA  = 4'h1,
    OP_STA  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_JMP  = 4'h8,
    OP_JZ   = 4'h9,
    OP_JC   = 4'hA,
    OP_CALL = 4'hB,
    OP_RET  = 4'hC,
    OP_IN   = 4'hD,
    OP_OUT  = 4'hE,
    OP_HLT  = 4'hF
  } iq_opcode_e;

  typedef struct packed {
    logic [IQ_OPC_W-1:0]       opcode;
    logic [IQ_IW-IQ_OPC_W-1:0] operand;
  } iq_fields_t;

  // Opcode occupies the upper bits, so a packed cast is the field split
  function automatic iq_fields_t iq_split(input logic [IQ_IW-1:0] word);
    return iq_fields_t'(word);
  endfunction

endpackage

// File: rtl/iq_ptr_ctrl.sv
// iq_ptr_ctrl: pointer/count bookkeeping and push/pop/flush arbitration for
// the instruction queue.
// Ports:
//   iq_clk, iq_rst     clock, synchronous active-high reset
//   wr_en, rd_en       push / consume requests
//   flush              discard all queued entries
//   push_acc, pop_acc  accepted push / pop this cycle
//   byp_take           word bypassed straight to the consumer (IQ_BYPASS_EN only)
//   rd_ptr, wr_ptr     circular read / write pointers
//   count              entries held
// Build macro: IQ_BYPASS_EN enables the empty-queue bypass arbitration.
module iq_ptr_ctrl
  import iq_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             iq_clk,
  input  logic             iq_rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             flush,
  output logic             push_acc,
  output logic             pop_acc,
  output logic             byp_take,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [CNT_W-1:0] count
);

  logic not_empty;
  logic is_full;

  assign not_empty = (count != '0);
  assign is_full   = (count == CNT_W'(DEPTH));

  // Acceptance decisions. Flush wins over push and pop. A bypassed word is
  // consumed without ever being stored, so it must not count as a push.
  always_comb begin
`ifdef IQ_BYPASS_EN
    byp_take = !not_empty && wr_en && rd_en && !flush;
`else
    byp_take = 1'b0;
`endif
    pop_acc  = rd_en && not_empty && !flush;
    push_acc = wr_en && !flush && !byp_take && (!is_full || pop_acc);
  end

  // Pointer and count registers; DEPTH is a power of two so pointers wrap
  // naturally on overflow.
  always_ff @(posedge iq_clk) begin
    if (iq_rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_queue.sv
// instr_queue: DEPTH-entry instruction prefetch queue feeding the decoder.
// Presents the head word split into opcode/operand fields and holds the last
// consumed word when empty. Supports a single-cycle flush for taken branches.
// Ports:
//   iq_clk, iq_rst   clock, synchronous active-high reset
//   iq_in, iq_wr_en  fetched word and push request; iq_full when DEPTH held
//   iq_rd_en         decoder consumes the head
//   iq_flush         discard all queued entries
//   iq_out           head word, or last consumed word when empty
//   iq_opcode        iq_out[IW-1:IW-OPC_W]
//   iq_operand       iq_out[IW-OPC_W-1:0]
//   iq_valid         iq_out is an unconsumed instruction
//   iq_count         entries held
// Build macro: IQ_BYPASS_EN passes iq_in straight to iq_out when empty.
module instr_queue
  import iq_pkg::*;
#(
  parameter int IW    = IQ_IW,
  parameter int DEPTH = IQ_DEPTH,
  parameter int OPC_W = IQ_OPC_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              iq_clk,
  input  logic              iq_rst,
  input  logic [IW-1:0]     iq_in,
  input  logic              iq_wr_en,
  output logic              iq_full,
  input  logic              iq_rd_en,
  input  logic              iq_flush,
  output logic [IW-1:0]     iq_out,
  output logic [OPC_W-1:0]  iq_opcode,
  output logic [IW-OPC_W-1:0] iq_operand,
  output logic              iq_valid,
  output logic [CNT_W-1:0]  iq_count
);

  logic [IW-1:0]    mem [DEPTH];
  logic [IW-1:0]    hold;
  logic             push_acc;
  logic             pop_acc;
  logic             byp_take;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  iq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
    .iq_clk   (iq_clk),
    .iq_rst   (iq_rst),
    .wr_en    (iq_wr_en),
    .rd_en    (iq_rd_en),
    .flush    (iq_flush),
    .push_acc (push_acc),
    .pop_acc  (pop_acc),
    .byp_take (byp_take),
    .rd_ptr   (rd_ptr),
    .wr_ptr   (wr_ptr),
    .count    (count)
  );

  // Storage and hold register. Everything is cleared on reset so the output
  // is never X. Hold captures whatever the decoder just consumed, either the
  // stored head or a bypassed word.
  always_ff @(posedge iq_clk) begin
    if (iq_rst) begin
      hold <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_acc) mem[wr_ptr] <= iq_in;
      if (byp_take)     hold <= iq_in;
      else if (pop_acc) hold <= mem[rd_ptr];
    end
  end

  // Output selection: head when non-empty, otherwise the held word. With the
  // bypass build, an incoming word on an empty queue is shown immediately.
  always_comb begin
    iq_valid = (count != '0);
    iq_out   = iq_valid ? mem[rd_ptr] : hold;
`ifdef IQ_BYPASS_EN
    if ((count == '0) && iq_wr_en && !iq_flush) begin
      iq_valid = 1'b1;
      iq_out   = iq_in;
    end
`endif
  end

  assign iq_full    = (count == CNT_W'(DEPTH));
  assign iq_count   = count;
  assign iq_opcode  = iq_out[IW-1:IW-OPC_W];
  assign iq_operand = iq_out[IW-OPC_W-1:0];

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed scoreboard bench for instr_queue (default sizes).
// Words expected to be accepted are queued as they are issued; a monitor on
// the falling edge pops and compares whenever the decoder consumes a word.
module tb_instr_queue;

  logic       iq_clk;
  logic       iq_rst;
  logic [7:0] iq_in;
  logic       iq_wr_en;
  logic       iq_full;
  logic       iq_rd_en;
  logic       iq_flush;
  logic [7:0] iq_out;
  logic [3:0] iq_opcode;
  logic [3:0] iq_operand;
  logic       iq_valid;
  logic [2:0] iq_count;

  int checkCount = 0;
  int passCount  = 0;
  logic [7:0] expQ[$];

  instr_queue dut (
    .iq_clk     (iq_clk),
    .iq_rst     (iq_rst),
    .iq_in      (iq_in),
    .iq_wr_en   (iq_wr_en),
    .iq_full    (iq_full),
    .iq_rd_en   (iq_rd_en),
    .iq_flush   (iq_flush),
    .iq_out     (iq_out),
    .iq_opcode  (iq_opcode),
    .iq_operand (iq_operand),
    .iq_valid   (iq_valid),
    .iq_count   (iq_count)
  );

  initial iq_clk = 1'b0;
  always #5 iq_clk = ~iq_clk;

  // Single comparison with pass/fail bookkeeping
  task automatic checkOne(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Status comparison of the queue's visible state
  task automatic checkOutput(input string name, input logic [7:0] expOut, input logic expValid,
                             input logic [2:0] expCount, input logic expFull);
    checkOne({name, ".out"},   iq_out,          expOut);
    checkOne({name, ".valid"}, {7'd0, iq_valid}, {7'd0, expValid});
    checkOne({name, ".count"}, {5'd0, iq_count}, {5'd0, expCount});
    checkOne({name, ".full"},  {7'd0, iq_full},  {7'd0, expFull});
  endtask

  // Drive one cycle of stimulus, then return to idle just after the edge
  task automatic applyStimulus(input logic wr, input logic [7:0] d, input logic rd,
                               input logic fl, input logic expPush);
    iq_wr_en = wr;
    iq_in    = d;
    iq_rd_en = rd;
    iq_flush = fl;
    if (fl) expQ.delete();
    if (expPush) expQ.push_back(d);
    @(posedge iq_clk);
    #1;
    iq_wr_en = 1'b0;
    iq_in    = 8'h00;
    iq_rd_en = 1'b0;
    iq_flush = 1'b0;
  endtask

  // Monitor: every accepted consumption must match the oldest expected word
  always @(negedge iq_clk) begin
    if (!iq_rst && !iq_flush && iq_rd_en && iq_valid) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL pop_underflow: got %h, expected no consumable word", iq_out);
      end else begin
        logic [7:0] e;
        e = expQ.pop_front();
        checkOne("pop.word",    iq_out,            e);
        checkOne("pop.opcode",  {4'd0, iq_opcode},  {4'd0, e[7:4]});
        checkOne("pop.operand", {4'd0, iq_operand}, {4'd0, e[3:0]});
      end
    end
  end

  logic [7:0] wrapWords [10] = '{8'h5E, 8'h61, 8'h72, 8'h83, 8'h94,
                                 8'hA5, 8'hB6, 8'hC7, 8'hD8, 8'hE9};
  logic [7:0] fillWords [4]  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

  initial begin
    iq_rst = 1'b1; iq_in = 8'h00; iq_wr_en = 1'b0; iq_rd_en = 1'b0; iq_flush = 1'b0;
    repeat (2) @(posedge iq_clk);
    #1 iq_rst = 1'b0;
    checkOutput("reset", 8'h00, 1'b0, 3'd0, 1'b0);

    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("idle_rd", 8'h00, 1'b0, 3'd0, 1'b0);

    // Fill to full, then a lone push must be dropped
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, fillWords[i], 1'b0, 1'b0, 1'b1);
      checkOne("fill.count", {5'd0, iq_count}, 8'(i + 1));
    end
    checkOutput("full", 8'hA1, 1'b1, 3'd4, 1'b1);
    applyStimulus(1'b1, 8'hE5, 1'b0, 1'b0, 1'b0);
    checkOutput("full_reject", 8'hA1, 1'b1, 3'd4, 1'b1);

    // Drain; last consumed word stays visible
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("drained", 8'hD4, 1'b0, 3'd0, 1'b0);

    // Refill, then push+pop while full across pointer wrap
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, fillWords[i], 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, wrapWords[i], 1'b1, 1'b0, 1'b1);
      checkOne("wrap.count", {5'd0, iq_count}, 8'd4);
    end
    checkOutput("wrap_end", 8'hB6, 1'b1, 3'd4, 1'b1);

    // Pop one (B6) leaving three, then flush with push and pop requested
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_flush", 8'hC7, 1'b1, 3'd3, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    checkOutput("flush", 8'hB6, 1'b0, 3'd0, 1'b0);

    // Reset in the middle of traffic
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    checkOutput("two_queued", 8'h11, 1'b1, 3'd2, 1'b0);
    iq_rst = 1'b1; iq_wr_en = 1'b1; iq_in = 8'h33; iq_rd_en = 1'b1;
    expQ.delete();
    @(posedge iq_clk);
    #1;
    iq_rst = 1'b0; iq_wr_en = 1'b0; iq_in = 8'h00; iq_rd_en = 1'b0;
    checkOutput("mid_reset", 8'h00, 1'b0, 3'd0, 1'b0);

    // Push with simultaneous read on an empty queue
    iq_wr_en = 1'b1; iq_in = 8'h3C; iq_rd_en = 1'b1;
    expQ.push_back(8'h3C);
    #2;
`ifdef IQ_BYPASS_EN
    checkOne("byp_same.out",   iq_out,           8'h3C);
    checkOne("byp_same.valid", {7'd0, iq_valid}, 8'd1);
`else
    checkOne("byp_same.out",   iq_out,           8'h00);
    checkOne("byp_same.valid", {7'd0, iq_valid}, 8'd0);
`endif
    @(posedge iq_clk);
    #1;
    iq_wr_en = 1'b0; iq_in = 8'h00; iq_rd_en = 1'b0;
`ifdef IQ_BYPASS_EN
    checkOutput("byp_next", 8'h3C, 1'b0, 3'd0, 1'b0);
`else
    checkOutput("byp_next", 8'h3C, 1'b1, 3'd1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("byp_drain", 8'h3C, 1'b0, 3'd0, 1'b0);
`endif

    // Every expected word must have been consumed
    checkOne("scoreboard_left", 8'(expQ.size()), 8'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Parametrised successor to the single 8-bit instruction register: a DEPTH-entry instruction prefetch queue feeding the decoder.
- Accepts fetched words from instruction memory and presents the head word split into opcode and operand fields.
- Holds the last consumed instruction when empty, with no latch inference.
- Supports a single-cycle flush for taken branches/jumps.

Parameters:
IW, 8, instruction word width in bits
DEPTH, 4, queue entries; power of two, >= 2
OPC_W, 4, opcode field width (upper OPC_W bits of the word); 1 <= OPC_W < IW

Ports:
iq_clk  input  1  clock; all state updates on rising edge
iq_rst  input  1  synchronous, active-high reset
iq_in  input  IW  fetched instruction word
iq_wr_en  input  1  push request
iq_full  output  1  queue holds DEPTH entries
iq_rd_en  input  1  decoder consumes head
iq_flush  input  1  discard all queued entries
iq_out  output  IW  head instruction, or last consumed word when empty
iq_opcode  output  OPC_W  iq_out[IW-1:IW-OPC_W]
iq_operand  output  IW-OPC_W  iq_out[IW-OPC_W-1:0]
iq_valid  output  1  iq_out is an unconsumed instruction
iq_count  output  $clog2(DEPTH+1)  entries held

Behaviour:
- Single clock iq_clk. Reset iq_rst is synchronous, active-high; these are fixed.
- Storage: circular array mem[DEPTH]; rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH; count is a separate register.
- Reset (highest priority): rd_ptr, wr_ptr, count, hold register and all mem entries go to 0. After reset: iq_out=0, iq_valid=0, iq_full=0, iq_count=0.
- Push accepted when iq_wr_en && (!iq_full || pop_acc). Pushing into a full queue is legal only in a cycle that also pops.
  - On accept: mem[wr_ptr] <= iq_in; wr_ptr increments.
  - A rejected push is dropped silently. The writer must hold the word until !iq_full.
- Pop accepted (pop_acc) when iq_rd_en && iq_valid. On accept: hold <= mem[rd_ptr]; rd_ptr increments. iq_rd_en while empty is ignored.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds DEPTH or underflows.
- Flush (priority below reset, above push/pop):
  - rd_ptr, wr_ptr and count are cleared.
  - A push or pop in the same cycle is discarded.
  - hold is not updated.
  - iq_valid=0 from the next cycle.
- Outputs:
  - iq_valid = (count != 0).
  - iq_full = (count == DEPTH).
  - iq_out = iq_valid ? mem[rd_ptr] : hold.
  - iq_opcode and iq_operand are pure field slices of iq_out.
  - When empty, iq_out always equals the last consumed word (or 0 after reset), never X.
- Latency: a word pushed into an empty queue appears on iq_out with iq_valid=1 one cycle after the push edge. Sustained throughput is 1 word/cycle with simultaneous push+pop.
- Order is strictly FIFO, including across pointer wrap-around.

Optional Feature:
- Macro: IQ_BYPASS_EN.
- Defined: when count==0, iq_wr_en=1 and iq_flush=0, then iq_out=iq_in and iq_valid=1 combinationally in the same cycle.
  - If iq_rd_en is also 1 that cycle, the word is consumed without being stored: hold <= iq_in, and pointers and count are unchanged.
  - If iq_rd_en is 0, the word is stored normally.
- Undefined: no combinational path from iq_in or iq_wr_en to iq_out or iq_valid; empty-queue latency is 1 cycle.

Decomposition:
- Package iq_pkg: default IW/OPC_W/DEPTH localparams, opcode field constants (opcode enum for the 8-bit ISA), and a function that slices opcode/operand from a word.
- One natural sub-module: iq_ptr_ctrl.
  - Holds the pointer/count registers and the push/pop/flush arbitration.
  - Outputs push_acc, pop_acc, rd_ptr, wr_ptr, count.
  - The top level holds mem, hold and output muxing.

Test Plan:
- Reset then idle: iq_rst=1 for 2 cycles -> iq_out=8'h00, iq_valid=0, iq_count=0, iq_full=0; iq_rd_en=1 while empty -> no change.
- Fill/drain: push 8'hA1,8'hB2,8'hC3,8'hD4 -> iq_full=1, iq_count=4; push 8'hE5 alone is rejected; pop 4 times -> iq_opcode 4'hA,B,C,D in order, then iq_valid=0 and iq_out holds 8'hD4.
- Full with simultaneous push+pop: when full, push 8'h5E and pop in the same cycle -> iq_count stays 4; 8'h5E emerges after 8'hB2..D4. Run 10 such cycles to cross wrap-around -> order preserved.
- Flush: 3 entries queued, then iq_flush=1 with iq_wr_en=1 (8'h77) and iq_rd_en=1 -> next cycle iq_count=0, iq_valid=0; iq_out shows the last word popped before the flush, 8'h77 is not stored and nothing is popped.
- Reset mid-operation: 2 entries queued, iq_rst=1 with push and pop asserted -> next cycle all outputs 0; queue empty.
- Bypass (IQ_BYPASS_EN): empty queue, push 8'h3C with iq_rd_en=1 -> iq_out=8'h3C, iq_valid=1 in the same cycle; next cycle iq_count=0 and iq_out=8'h3C from hold. Without the macro, iq_valid=0 in that cycle and 8'h3C is stored.
